// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches in EX, checks fetch's prediction, and generates the
// predictor training pulse, the flush redirect and the load-use stall bubble.
// Optional: define BRANCH_RESOLVE_STATS_EN to add the saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ID_EX_branch,
    input  logic [2:0]      ID_EX_funct3,
    input  logic [XLEN-1:0] ID_EX_rs1_data,
    input  logic [XLEN-1:0] ID_EX_rs2_data,
    input  logic            IF_take,
    input  logic            ID_EX_mem_read,
    input  logic [4:0]      ID_EX_rd,
    input  logic [4:0]      IF_ID_rs1,
    input  logic [4:0]      IF_ID_rs2,
    output logic            EX_MEM_branch,
    output logic            EX_MEM_zero,
    output logic            EX_MEM_flush,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            EX_MEM_stall
);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic       taken_q, taken_d;
    logic       branch_q, branch_d;
    logic       zero_q, zero_d;
    logic       flush_q, flush_d;
    logic       stall_q, stall_d;
    logic       lockout_q, lockout_d;
    logic [2:0] cnt_q, cnt_d;

    logic cond_legal;
    logic cond_taken;
    logic stall_cond;
    logic stall_take;
    logic accept;

    always_comb begin
        cond_legal = 1'b1;
        cond_taken = 1'b0;
        case (ID_EX_funct3)
            3'b000:  cond_taken = (ID_EX_rs1_data == ID_EX_rs2_data);
            3'b001:  cond_taken = (ID_EX_rs1_data != ID_EX_rs2_data);
            3'b100:  cond_taken = ($signed(ID_EX_rs1_data) <  $signed(ID_EX_rs2_data));
            3'b101:  cond_taken = ($signed(ID_EX_rs1_data) >= $signed(ID_EX_rs2_data));
            3'b110:  cond_taken = (ID_EX_rs1_data <  ID_EX_rs2_data);
            3'b111:  cond_taken = (ID_EX_rs1_data >= ID_EX_rs2_data);
            default: cond_legal = 1'b0;
        endcase
    end

    // The lockout stops a held load-use pair from producing a second bubble.
    assign stall_cond = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                        ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
    assign stall_take = stall_cond && !lockout_q;
    assign accept     = ID_EX_branch && !stall_take && cond_legal;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        taken_d   = taken_q;
        branch_d  = 1'b0;
        zero_d    = zero_q;
        flush_d   = flush_q;
        cnt_d     = cnt_q;
        stall_d   = stall_take;
        lockout_d = stall_take;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    taken_d = cond_taken;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                branch_d = 1'b1;
                zero_d   = taken_q;
                if (IF_take != taken_q) begin
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_LOAD;
                    state_d = FLUSH;
                end else if (accept) begin
                    taken_d = cond_taken;
                    state_d = RESOLVE;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // Fetch honours the stall first, so the redirect window freezes under it.
                if (!stall_q) begin
                    if (cnt_q == 3'd0) begin
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            taken_q   <= 1'b0;
            branch_q  <= 1'b0;
            zero_q    <= 1'b0;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
            lockout_q <= 1'b0;
            cnt_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            taken_q   <= taken_d;
            branch_q  <= branch_d;
            zero_q    <= zero_d;
            flush_q   <= flush_d;
            stall_q   <= stall_d;
            lockout_q <= lockout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign EX_MEM_branch = branch_q;
    assign EX_MEM_zero   = zero_q;
    assign EX_MEM_flush  = flush_q;
    assign EX_MEM_stall  = stall_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            if (state_q == RESOLVE && stat_branches_q != 32'hFFFF_FFFF)
                stat_branches_q <= stat_branches_q + 32'd1;
            if (state_q == RESOLVE && state_d == FLUSH && stat_mispredicts_q != 32'hFFFF_FFFF)
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: outcome/training, flush window, load-use
// stall, reset mid-flush and, with BRANCH_RESOLVE_STATS_EN, the statistics counters.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            ID_EX_branch;
    logic [2:0]      ID_EX_funct3;
    logic [XLEN-1:0] ID_EX_rs1_data;
    logic [XLEN-1:0] ID_EX_rs2_data;
    logic            IF_take;
    logic            ID_EX_mem_read;
    logic [4:0]      ID_EX_rd;
    logic [4:0]      IF_ID_rs1;
    logic [4:0]      IF_ID_rs2;
    logic            EX_MEM_branch;
    logic            EX_MEM_zero;
    logic            EX_MEM_flush;
    logic            EX_MEM_stall;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_EX_branch   (ID_EX_branch),
        .ID_EX_funct3   (ID_EX_funct3),
        .ID_EX_rs1_data (ID_EX_rs1_data),
        .ID_EX_rs2_data (ID_EX_rs2_data),
        .IF_take        (IF_take),
        .ID_EX_mem_read (ID_EX_mem_read),
        .ID_EX_rd       (ID_EX_rd),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .EX_MEM_branch  (EX_MEM_branch),
        .EX_MEM_zero    (EX_MEM_zero),
        .EX_MEM_flush   (EX_MEM_flush),
`ifdef BRANCH_RESOLVE_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .EX_MEM_stall   (EX_MEM_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        ID_EX_branch   = 1'b1;
        ID_EX_funct3   = f3;
        ID_EX_rs1_data = a;
        ID_EX_rs2_data = b;
        step();
        ID_EX_branch   = 1'b0;
    endtask

    task automatic resolve(input logic take);
        IF_take = take;
        step();
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        ID_EX_branch   = 1'b0;
        ID_EX_funct3   = 3'b000;
        ID_EX_rs1_data = '0;
        ID_EX_rs2_data = '0;
        IF_take        = 1'b0;
        ID_EX_mem_read = 1'b0;
        ID_EX_rd       = 5'd0;
        IF_ID_rs1      = 5'd0;
        IF_ID_rs2      = 5'd0;
        step();
        step();
        check("reset_outputs", {28'd0, EX_MEM_branch, EX_MEM_zero, EX_MEM_flush, EX_MEM_stall}, 32'd0);
        reset = 1'b0;
        step();

        // beq 5==5 predicted taken: pulse, no flush
        present(3'b000, 32'd5, 32'd5);
        resolve(1'b1);
        check("beq_branch", EX_MEM_branch, 1);
        check("beq_zero", EX_MEM_zero, 1);
        check("beq_flush", EX_MEM_flush, 0);
        step();
        check("beq_pulse_end", EX_MEM_branch, 0);
        check("beq_zero_hold", EX_MEM_zero, 1);

        // back-to-back: bne presented while the previous beq resolves
        present(3'b000, 32'd7, 32'd7);
        ID_EX_branch = 1'b1; ID_EX_funct3 = 3'b001; ID_EX_rs1_data = 32'd1; ID_EX_rs2_data = 32'd2;
        resolve(1'b1);
        ID_EX_branch = 1'b0;
        check("b2b_first_branch", EX_MEM_branch, 1);
        check("b2b_first_flush", EX_MEM_flush, 0);
        resolve(1'b1);
        check("b2b_second_branch", EX_MEM_branch, 1);
        check("b2b_second_zero", EX_MEM_zero, 1);
        step();

        // blt -1 < 1 signed: taken, predicted not-taken -> 2-cycle flush
        present(3'b100, 32'hFFFF_FFFF, 32'd1);
        resolve(1'b0);
        check("blt_branch", EX_MEM_branch, 1);
        check("blt_zero", EX_MEM_zero, 1);
        check("blt_flush_c1", EX_MEM_flush, 1);
        step();
        check("blt_flush_c2", EX_MEM_flush, 1);
        check("blt_pulse_end", EX_MEM_branch, 0);
        step();
        check("blt_flush_off", EX_MEM_flush, 0);

        // bltu 0xFFFFFFFF < 1 unsigned: not taken, predicted taken; wrong-path branch ignored
        present(3'b110, 32'hFFFF_FFFF, 32'd1);
        resolve(1'b1);
        check("bltu_branch", EX_MEM_branch, 1);
        check("bltu_zero", EX_MEM_zero, 0);
        check("bltu_flush_c1", EX_MEM_flush, 1);
        ID_EX_branch = 1'b1; ID_EX_funct3 = 3'b000; ID_EX_rs1_data = 32'd3; ID_EX_rs2_data = 32'd3;
        step();
        ID_EX_branch = 1'b0;
        check("bltu_flush_c2", EX_MEM_flush, 1);
        check("wrongpath_no_pulse_a", EX_MEM_branch, 0);
        step();
        check("bltu_flush_off", EX_MEM_flush, 0);
        check("wrongpath_no_pulse_b", EX_MEM_branch, 0);
        step();
        check("wrongpath_no_pulse_c", EX_MEM_branch, 0);

        // bgeu 0xFFFFFFFF >= 1 unsigned: taken, predicted taken
        present(3'b111, 32'hFFFF_FFFF, 32'd1);
        resolve(1'b1);
        check("bgeu_zero", EX_MEM_zero, 1);
        check("bgeu_flush", EX_MEM_flush, 0);
        step();

        // illegal funct3 010: no pulse, zero holds
        present(3'b010, 32'd5, 32'd5);
        resolve(1'b0);
        check("illegal_no_pulse", EX_MEM_branch, 0);
        check("illegal_zero_hold", EX_MEM_zero, 1);
        check("illegal_no_flush", EX_MEM_flush, 0);

        // load-use: rd=x5, rs2=x5 held two cycles -> one bubble
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5;
        step();
        check("stall_c1", EX_MEM_stall, 1);
        step();
        check("stall_c2_lockout", EX_MEM_stall, 0);
        ID_EX_mem_read = 1'b0; ID_EX_rd = 5'd0; IF_ID_rs2 = 5'd0;
        step();
        check("stall_c3", EX_MEM_stall, 0);
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0;
        step();
        check("stall_x0", EX_MEM_stall, 0);
        ID_EX_mem_read = 1'b0;

        // branch coinciding with a stall is deferred until after the bubble
        ID_EX_branch = 1'b1; ID_EX_funct3 = 3'b000; ID_EX_rs1_data = 32'd9; ID_EX_rs2_data = 32'd9;
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd4; IF_ID_rs2 = 5'd4;
        step();
        check("bstall_stall", EX_MEM_stall, 1);
        step();
        check("bstall_no_pulse", EX_MEM_branch, 0);
        check("bstall_stall_off", EX_MEM_stall, 0);
        ID_EX_branch = 1'b0; ID_EX_mem_read = 1'b0; ID_EX_rd = 5'd0; IF_ID_rs2 = 5'd0;
        resolve(1'b1);
        check("bstall_pulse", EX_MEM_branch, 1);
        check("bstall_zero", EX_MEM_zero, 1);
        step();

        // mispredict with a stall in the first FLUSH cycle -> flush 3 cycles
        present(3'b000, 32'd1, 32'd2);
        IF_take = 1'b1; ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd7;
        step();
        ID_EX_mem_read = 1'b0; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0;
        check("sf_zero", EX_MEM_zero, 0);
        check("sf_stall", EX_MEM_stall, 1);
        check("sf_flush_start", EX_MEM_flush, 1);
        n = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (EX_MEM_flush) n++;
            else break;
        end
        check("sf_flush_len", n, 3);

        // reset while in FLUSH
        present(3'b000, 32'd1, 32'd1);
        resolve(1'b0);
        check("rst_pre_flush", EX_MEM_flush, 1);
        reset = 1'b1;
        #1;
        check("rst_async_outputs", {28'd0, EX_MEM_branch, EX_MEM_zero, EX_MEM_flush, EX_MEM_stall}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rst_post_outputs", {28'd0, EX_MEM_branch, EX_MEM_zero, EX_MEM_flush, EX_MEM_stall}, 32'd0);

        // three branches after reset, the last one mispredicted
        present(3'b000, 32'd5, 32'd5);
        resolve(1'b1);
        present(3'b001, 32'd5, 32'd5);
        resolve(1'b0);
        check("bne_equal_zero", EX_MEM_zero, 0);
        present(3'b101, 32'd1, 32'd2);
        resolve(1'b1);
        check("bge_zero", EX_MEM_zero, 0);
        check("bge_flush", EX_MEM_flush, 1);
        step();
        step();
        check("bge_flush_off", EX_MEM_flush, 0);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("stat_branches", stat_branches, 32'd3);
        check("stat_mispredicts", stat_mispredicts, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart to the fetch-stage predictor.
- Evaluates the branch condition in ID/EX and compares the actual outcome with the prediction fetch returns on IF_take.
- Produces the EX_MEM_branch/EX_MEM_zero training pulse, the EX_MEM_flush redirect and the EX_MEM_stall load-use bubble that fetch consumes.
- Sits between the ID/EX register and the fetch stage.

Parameters:
- FLUSH_CYCLES, 2, number of cycles EX_MEM_flush is held to squash wrong-path fetches (legal 1..7).
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ID_EX_branch  in  1  conditional branch present in ID/EX this cycle
- ID_EX_funct3  in  3  branch type: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
- ID_EX_rs1_data  in  XLEN  first compare operand (already forwarded)
- ID_EX_rs2_data  in  XLEN  second compare operand
- IF_take  in  1  prediction returned by fetch, valid the cycle after ID_EX_branch
- ID_EX_mem_read  in  1  load in ID/EX
- ID_EX_rd  in  5  load destination register
- IF_ID_rs1  in  5  source register of the next instruction
- IF_ID_rs2  in  5  source register of the next instruction
- EX_MEM_branch  out  1  resolved-branch pulse that trains the predictor
- EX_MEM_zero  out  1  actual outcome, 1 = taken
- EX_MEM_flush  out  1  misprediction redirect
- EX_MEM_stall  out  1  load-use bubble

Behaviour:
- Reset values: state IDLE; all outputs 0; flush counter 0; stall lockout 0; outcome register 0.
- All outputs are driven from registers only.
- Condition evaluation:
  - eq/ne compare all XLEN bits.
  - blt/bge use signed compare; bltu/bgeu use unsigned compare.
  - funct3 010/011 is illegal: outcome not-taken, no EX_MEM_branch pulse, state stays IDLE.
- FSM states: IDLE, RESOLVE, FLUSH.
- IDLE:
  - If ID_EX_branch=1 and the stall condition is not being taken this cycle: register taken=cond(funct3) and go to RESOLVE.
  - Otherwise stay in IDLE.
- RESOLVE (exactly one cycle, edge N+1 after branch sampled at N):
  - Sample IF_take.
  - At the closing edge, EX_MEM_branch=1 and EX_MEM_zero=taken for exactly one cycle.
  - If IF_take != taken: EX_MEM_flush=1, load counter with FLUSH_CYCLES-1, go to FLUSH.
  - Otherwise go to IDLE. A back-to-back ID_EX_branch in this cycle is accepted as in IDLE.
- FLUSH:
  - EX_MEM_flush stays 1; counter decrements each cycle EX_MEM_stall=0.
  - At count 0 with no stall: deassert and go to IDLE.
  - ID_EX_branch seen in FLUSH belongs to the wrong path and is ignored: no training pulse.
- EX_MEM_zero holds its last value between pulses.
- Load-use stall:
  - Condition: ID_EX_mem_read & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2).
  - Registered: EX_MEM_stall=1 for exactly one cycle.
  - Lockout bit set while EX_MEM_stall=1 prevents re-trigger on the same held instruction next cycle.
- Simultaneous stall and flush:
  - Stall has priority in fetch, so the flush counter freezes while EX_MEM_stall=1.
  - Flush is therefore visible for FLUSH_CYCLES non-stalled cycles.
- Simultaneous ID_EX_branch and stall condition: the branch is not captured; it is re-presented after the bubble.
- Reset mid-FLUSH or mid-RESOLVE: immediate return to IDLE, outputs 0, no training pulse emitted.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on each EX_MEM_branch pulse.
  - stat_mispredicts increments on each RESOLVE→FLUSH transition.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- beq, rs1=rs2=5, IF_take=1 → EX_MEM_branch=1, EX_MEM_zero=1 one cycle after; EX_MEM_flush stays 0.
- blt, rs1=0xFFFFFFFF, rs2=1, IF_take=0 → taken=1 (signed); EX_MEM_flush=1 for exactly 2 cycles; then IDLE.
- bltu, same operands, IF_take=1 → taken=0; flush 2 cycles; ID_EX_branch pulsed during FLUSH gives no EX_MEM_branch.
- Load with rd=x5 in ID/EX, IF_ID_rs2=5 held for 2 cycles → EX_MEM_stall=1 for exactly 1 cycle; rd=x0 → no stall.
- Mispredict with a stall pulse in the first FLUSH cycle → EX_MEM_flush high 3 cycles total. Assert reset during FLUSH → all outputs 0 next cycle.
- With BRANCH_RESOLVE_STATS_EN: 3 branches, 1 mispredicted → stat_branches=3, stat_mispredicts=1.
